// File: rtl/seg7_pkg.sv
// Shared constants and types for the multiplexed 7-segment scan driver.
package seg7_pkg;

  localparam int unsigned SEG_W   = 7;
  localparam int unsigned DIGIT_W = 4;
  localparam int unsigned AN_W    = 4;

  // Patterns are {g,f,e,d,c,b,a}, active low.
  localparam logic [SEG_W-1:0] SEG_0    = 7'b1000000;
  localparam logic [SEG_W-1:0] SEG_1    = 7'b1111001;
  localparam logic [SEG_W-1:0] SEG_2    = 7'b0100100;
  localparam logic [SEG_W-1:0] SEG_3    = 7'b0110000;
  localparam logic [SEG_W-1:0] SEG_4    = 7'b0011001;
  localparam logic [SEG_W-1:0] SEG_5    = 7'b0010010;
  localparam logic [SEG_W-1:0] SEG_6    = 7'b0000010;
  localparam logic [SEG_W-1:0] SEG_7    = 7'b1111000;
  localparam logic [SEG_W-1:0] SEG_8    = 7'b0000000;
  localparam logic [SEG_W-1:0] SEG_9    = 7'b0010000;
  localparam logic [SEG_W-1:0] SEG_DASH = 7'b0111111;
  localparam logic [SEG_W-1:0] SEG_OFF  = 7'b1111111;

  localparam logic [AN_W-1:0] ANODES_OFF = 4'b1111;

  typedef enum logic [1:0] {
    SLOT_ONES     = 2'd0,
    SLOT_TENS     = 2'd1,
    SLOT_HUNDREDS = 2'd2,
    SLOT_UNUSED   = 2'd3
  } slot_t;

  typedef struct packed {
    logic [DIGIT_W-1:0] hundreds;
    logic [DIGIT_W-1:0] tens;
    logic [DIGIT_W-1:0] ones;
  } bcd_digits_t;

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD to active-low 7-segment pattern; non-BCD codes show a dash.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [DIGIT_W-1:0] digit,
  output logic [SEG_W-1:0]   pattern_c
);

  always_comb begin
    pattern_c = SEG_DASH;
    case (digit)
      4'd0:    pattern_c = SEG_0;
      4'd1:    pattern_c = SEG_1;
      4'd2:    pattern_c = SEG_2;
      4'd3:    pattern_c = SEG_3;
      4'd4:    pattern_c = SEG_4;
      4'd5:    pattern_c = SEG_5;
      4'd6:    pattern_c = SEG_6;
      4'd7:    pattern_c = SEG_7;
      4'd8:    pattern_c = SEG_8;
      4'd9:    pattern_c = SEG_9;
      default: pattern_c = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/bcd_seg7_scan.sv
// Double-buffered 3-digit scan driver for a 4-digit common-anode display.
// Define LEADING_ZERO_BLANK_EN to suppress leading zeros in the hundreds/tens slots.
module bcd_seg7_scan
  import seg7_pkg::*;
#(
  parameter int unsigned REFRESH_DIV  = 100000,
  parameter int unsigned BLANK_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [3:0] ones,
  input  logic [3:0] tens,
  input  logic [3:0] hundreds,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       frame_done
);

  localparam int unsigned PW = $clog2(REFRESH_DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [PW-1:0] BLANK_END  = PW'(BLANK_CYCLES);

  logic [PW-1:0]    presc, presc_next;
  slot_t            slot, slot_next;
  bcd_digits_t      active, active_next;
  bcd_digits_t      pending, pending_next;
  logic             pending_valid, pending_valid_next;
  logic             boundary_c;
  logic [3:0]       digit_c;
  logic [SEG_W-1:0] pattern_c;
  logic [AN_W-1:0]  an_slot_c, an_next;
  logic [SEG_W-1:0] seg_next;
  logic             slot_lit_c;

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc         <= '0;
      slot          <= SLOT_ONES;
      active        <= '0;
      pending       <= '0;
      pending_valid <= 1'b0;
      an            <= ANODES_OFF;
      seg           <= SEG_OFF;
      dp            <= 1'b1;
      frame_done    <= 1'b0;
    end else begin
      presc         <= presc_next;
      slot          <= slot_next;
      active        <= active_next;
      pending       <= pending_next;
      pending_valid <= pending_valid_next;
      an            <= an_next;
      seg           <= seg_next;
      dp            <= 1'b1;
      frame_done    <= boundary_c;
    end
  end

  // Prescaler, slot sequencing and double-buffer commit.
  always_comb begin
    presc_next         = presc + PW'(1);
    slot_next          = slot;
    boundary_c         = 1'b0;
    active_next        = active;
    pending_next       = pending;
    pending_valid_next = pending_valid;

    if (presc == PRESC_LAST) begin
      presc_next = '0;
      slot_next  = slot_t'(slot + 2'd1);
      boundary_c = (slot == SLOT_UNUSED);
    end

    // Commit uses the pending value from before this cycle's load.
    if (boundary_c && pending_valid) begin
      active_next        = pending;
      pending_valid_next = 1'b0;
    end

    if (load) begin
      pending_next.hundreds = hundreds;
      pending_next.tens     = tens;
      pending_next.ones     = ones;
      pending_valid_next    = 1'b1;
    end
  end

  // Per-slot digit selection and anode pattern.
  always_comb begin
    digit_c    = '0;
    an_slot_c  = ANODES_OFF;
    slot_lit_c = 1'b0;
    case (slot)
      SLOT_ONES: begin
        digit_c    = active.ones;
        an_slot_c  = 4'b1110;
        slot_lit_c = 1'b1;
      end
      SLOT_TENS: begin
        digit_c    = active.tens;
        an_slot_c  = 4'b1101;
`ifdef LEADING_ZERO_BLANK_EN
        slot_lit_c = !((active.hundreds == 4'd0) && (active.tens == 4'd0));
`else
        slot_lit_c = 1'b1;
`endif
      end
      SLOT_HUNDREDS: begin
        digit_c    = active.hundreds;
        an_slot_c  = 4'b1011;
`ifdef LEADING_ZERO_BLANK_EN
        slot_lit_c = (active.hundreds != 4'd0);
`else
        slot_lit_c = 1'b1;
`endif
      end
      default: begin
        digit_c    = '0;
        an_slot_c  = ANODES_OFF;
        slot_lit_c = 1'b0;
      end
    endcase
  end

  seg7_decode u_decode (
    .digit     (digit_c),
    .pattern_c (pattern_c)
  );

  // Anodes stay off during the blanking window; segments are driven regardless.
  always_comb begin
    an_next  = ANODES_OFF;
    seg_next = (slot == SLOT_UNUSED) ? SEG_OFF : pattern_c;
    if (slot_lit_c && (presc >= BLANK_END)) begin
      an_next = an_slot_c;
    end
  end

endmodule
